// File: rtl/magma_block_engine_if.sv
// Handshake and data bundle between the keypad/display driver and the Magma block engine.
// The driver is the master; the cipher core is the slave.
interface magma_block_engine_if;
    logic         start;
    logic         decrypt;
    logic [255:0] key;
    logic [63:0]  data_in;
    logic         busy;
    logic         done;
    logic [63:0]  data_out;

    modport master (
        output start, decrypt, key, data_in,
        input  busy, done, data_out
    );

    modport slave (
        input  start, decrypt, key, data_in,
        output busy, done, data_out
    );
endinterface

// File: rtl/magma_block_engine.sv
// Iterative GOST R 34.12-2015 Magma block cipher (64-bit block, 256-bit key).
// RPC rounds per clock; a block takes 32/RPC cycles from accept to done.
module magma_block_engine #(
    parameter int unsigned RPC = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    magma_block_engine_if.slave   bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    localparam logic [4:0] RcStep = 5'(RPC);
    localparam logic [4:0] RcLast = 5'(32 - RPC);

    // Pi_j packed with entry x=0 in the top nibble.
    localparam logic [63:0] Pi [8] = '{
        64'hC462A5B9E8D703F1,
        64'h68239A5C1E47BD0F,
        64'hB3582FADE174C960,
        64'hC821D4F670A53E9B,
        64'h7F5A816D093EB42C,
        64'h5DF692CAB78143E0,
        64'h8E25691CF4B0DA37,
        64'h17ED05834FA69CB2
    };

    state_e        r_state;
    logic [4:0]    r_rc;
    logic [63:0]   r_a;
    logic [255:0]  r_key;
    logic          r_dec;
    logic          r_busy;
    logic          r_done;
    logic [63:0]   r_data_out;

    logic [31:0]   w_a1;
    logic [31:0]   w_a0;
    logic [31:0]   w_t;
    logic [31:0]   w_k;
    logic [4:0]    w_i;
    logic [2:0]    w_idx;
    logic          w_fwd;

    function automatic logic [31:0] f_sbox(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int j = 0; j < 8; j++) begin
            y[4*j +: 4] = Pi[j][63 - 4*int'(x[4*j +: 4]) -: 4];
        end
        return y;
    endfunction

    function automatic logic [31:0] f_g(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] s;
        s = f_sbox(x + k);
        return {s[20:0], s[31:21]};
    endfunction

    // Unrolled RPC rounds. The last round keeps a0 in place, so the swap is skipped at i=31.
    always_comb begin
        w_a1  = r_a[63:32];
        w_a0  = r_a[31:0];
        w_t   = '0;
        w_k   = '0;
        w_i   = '0;
        w_idx = '0;
        w_fwd = 1'b0;
        for (int unsigned r = 0; r < RPC; r++) begin
            w_i   = r_rc + 5'(r);
            w_fwd = r_dec ? (w_i < 5'd8) : (w_i < 5'd24);
            w_idx = w_fwd ? w_i[2:0] : ~w_i[2:0];
            w_k   = r_key[32*(7 - int'(w_idx)) +: 32];
            w_t   = f_g(w_a0, w_k) ^ w_a1;
            if (w_i == 5'd31) begin
                w_a1 = w_t;
            end else begin
                w_a1 = w_a0;
                w_a0 = w_t;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_rc       <= '0;
            r_a        <= '0;
            r_key      <= '0;
            r_dec      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.start) begin
                        r_a     <= bus.data_in;
                        r_key   <= bus.key;
                        r_dec   <= bus.decrypt;
                        r_rc    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_rc <= r_rc + RcStep;
                    r_a  <= {w_a1, w_a0};
                    if (r_rc == RcLast) begin
                        r_data_out <= {w_a1, w_a0};
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.data_out = r_data_out;

endmodule

// File: tb/tb_magma_block_engine.sv
// Directed bench for magma_block_engine: GOST test vectors, handshake corner cases,
// reset abort and RPC=1/2/4 latency.
module tb_magma_block_engine;

    localparam logic [255:0] TKey = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  TPt  = 64'hfedcba9876543210;
    localparam logic [63:0]  TCt  = 64'h4ee901e5c2d8ca3d;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    magma_block_engine_if bus1 ();
    magma_block_engine_if bus2 ();
    magma_block_engine_if bus4 ();

    magma_block_engine #(.RPC(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));
    magma_block_engine #(.RPC(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    magma_block_engine #(.RPC(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int sel, input logic s, input logic dec,
                         input logic [255:0] k, input logic [63:0] d);
        case (sel)
            2: begin bus2.start = s; bus2.decrypt = dec; bus2.key = k; bus2.data_in = d; end
            4: begin bus4.start = s; bus4.decrypt = dec; bus4.key = k; bus4.data_in = d; end
            default: begin bus1.start = s; bus1.decrypt = dec; bus1.key = k; bus1.data_in = d; end
        endcase
    endtask

    task automatic set_start(input int sel, input logic s);
        case (sel)
            2: bus2.start = s;
            4: bus4.start = s;
            default: bus1.start = s;
        endcase
    endtask

    function automatic logic get_done(input int sel);
        case (sel)
            2: return bus2.done;
            4: return bus4.done;
            default: return bus1.done;
        endcase
    endfunction

    function automatic logic get_busy(input int sel);
        case (sel)
            2: return bus2.busy;
            4: return bus4.busy;
            default: return bus1.busy;
        endcase
    endfunction

    function automatic logic [63:0] get_out(input int sel);
        case (sel)
            2: return bus2.data_out;
            4: return bus4.data_out;
            default: return bus1.data_out;
        endcase
    endfunction

    // One full operation: latency counted in edges after the accept edge.
    task automatic run_op(input int sel, input logic dec, input logic [63:0] d,
                          input int exp_lat, input logic [63:0] exp, input string name);
        int n;
        drive(sel, 1'b1, dec, TKey, d);
        tick();
        set_start(sel, 1'b0);
        n_checks++;
        if (get_busy(sel) !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, get_busy(sel));
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (get_done(sel) !== 1'b1 && n < 100);
        n_checks++;
        if (n != exp_lat) begin
            n_errors++;
            $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
        end
        n_checks++;
        if (get_out(sel) !== exp) begin
            n_errors++;
            $display("FAIL %s data_out: got %h want %h", name, get_out(sel), exp);
        end
        n_checks++;
        if (get_busy(sel) !== 1'b0) begin
            n_errors++;
            $display("FAIL %s busy_at_done: got %b want 0", name, get_busy(sel));
        end
        tick();
        n_checks++;
        if (get_done(sel) !== 1'b0 || get_out(sel) !== exp) begin
            n_errors++;
            $display("FAIL %s done_pulse_hold: got done=%b out=%h want done=0 out=%h",
                     name, get_done(sel), get_out(sel), exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, '0, '0);
        drive(2, 1'b0, 1'b0, '0, '0);
        drive(4, 1'b0, 1'b0, '0, '0);
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.data_out !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b out=%h want 0 0 0",
                     bus1.busy, bus1.done, bus1.data_out);
        end
        n_checks++;
        if (dut1.r_rc !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_counter: got %0d want 0", dut1.r_rc);
        end
        tick();
        n_checks++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_no_start: got busy=%b done=%b want 0 0", bus1.busy, bus1.done);
        end
    endtask

    task automatic test_round_trace();
        int n;
        drive(1, 1'b1, 1'b0, TKey, TPt);
        tick();
        set_start(1, 1'b0);
        tick();
        n_checks++;
        if (dut1.r_a !== 64'h76543210_28da3b14) begin
            n_errors++;
            $display("FAIL round0_state: got %h want 7654321028da3b14", dut1.r_a);
        end
        n = 0;
        while (bus1.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (bus1.data_out !== TCt || n != 31) begin
            n_errors++;
            $display("FAIL trace_result: got %h after %0d more edges want %h after 31",
                     bus1.data_out, n, TCt);
        end
        tick();
    endtask

    task automatic test_start_while_busy();
        int n;
        int dones;
        drive(1, 1'b1, 1'b0, TKey, TPt);
        tick();
        dones = 0;
        n = 0;
        while (n < 100) begin
            drive(1, 1'b1, $urandom_range(1), {8{$urandom}}, {$urandom, $urandom});
            tick();
            n++;
            if (bus1.done === 1'b1) begin
                dones++;
                set_start(1, 1'b0);
                break;
            end
        end
        n_checks++;
        if (bus1.data_out !== TCt || n != 32) begin
            n_errors++;
            $display("FAIL busy_start_result: got %h at %0d want %h at 32", bus1.data_out, n, TCt);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus1.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 1 || bus1.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_start_done_count: got %0d busy=%b want 1 busy=0", dones, bus1.busy);
        end
    endtask

    task automatic test_reset_mid_run();
        drive(1, 1'b1, 1'b0, TKey, TPt);
        tick();
        set_start(1, 1'b0);
        for (int c = 0; c < 9; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.data_out !== 64'h0) begin
            n_errors++;
            $display("FAIL reset_abort: got busy=%b done=%b out=%h want 0 0 0",
                     bus1.busy, bus1.done, bus1.data_out);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            n_checks++;
            if (bus1.done !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_no_done: got done=1 at cycle %0d want 0", c);
            end
            if (bus1.done !== 1'b0) break;
        end
        run_op(1, 1'b0, TPt, 32, TCt, "after_reset");
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1, 1'b1, 1'b0, TKey, TPt);
        tick();
        set_start(1, 1'b0);
        n = 0;
        while (bus1.done !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        n_checks++;
        if (bus1.data_out !== TCt) begin
            n_errors++;
            $display("FAIL b2b_first: got %h want %h", bus1.data_out, TCt);
        end
        drive(1, 1'b1, 1'b1, TKey, TCt);
        n = 0;
        do begin
            tick();
            set_start(1, 1'b0);
            n++;
        end while (bus1.done !== 1'b1 && n < 100);
        n_checks++;
        if (bus1.data_out !== TPt || n != 33) begin
            n_errors++;
            $display("FAIL b2b_second: got %h after %0d want %h after 33", bus1.data_out, n, TPt);
        end
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        test_reset();
        run_op(1, 1'b0, TPt, 32, TCt, "encrypt_rpc1");
        run_op(1, 1'b1, TCt, 32, TPt, "decrypt_rpc1");
        test_round_trace();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        run_op(2, 1'b0, TPt, 16, TCt, "encrypt_rpc2");
        run_op(2, 1'b1, TCt, 16, TPt, "decrypt_rpc2");
        run_op(4, 1'b0, TPt, 8, TCt, "encrypt_rpc4");
        run_op(4, 1'b1, TCt, 8, TPt, "decrypt_rpc4");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
